// File: rtl/row_window_buffer.sv
// Sliding row window: stores the last P_P_ROWS rows and emits, per accepted pixel,
// the vertical column of pixels at that position with rows not yet seen this frame zeroed.
module row_window_buffer #(
   parameter int unsigned P_P_COLUMNS     = 640,
   parameter int unsigned P_P_ROWS        = 3,
   parameter int unsigned P_P_PIXEL_DEPTH = 24
) (
   input  logic                                   I_CLK,
   input  logic                                   I_RESET,
   input  logic                                   I_ENABLE,
   input  logic [P_P_PIXEL_DEPTH-1:0]             I_PIXEL,
   input  logic                                   I_PIXEL_VALID,
   input  logic                                   I_FRAME_START,
   output logic [P_P_ROWS*P_P_PIXEL_DEPTH-1:0]    O_COLUMN,
   output logic                                   O_COLUMN_VALID,
   output logic [$clog2(P_P_COLUMNS)-1:0]         O_COL,
   output logic                                   O_WINDOW_READY,
   output logic                                   O_ROW_DONE
);

   localparam int unsigned COL_W = $clog2(P_P_COLUMNS);
   localparam int unsigned ROW_W = $clog2(P_P_ROWS);
   localparam int unsigned W     = P_P_PIXEL_DEPTH;

   logic [W-1:0]                 row_mem [P_P_ROWS][P_P_COLUMNS];

   logic [COL_W-1:0]             wcol_q, wcol_d;
   logic [ROW_W-1:0]             wrow_q, wrow_d;
   logic [ROW_W-1:0]             lines_done_q, lines_done_d;
   logic [P_P_ROWS*W-1:0]        column_q, column_d;
   logic [COL_W-1:0]             col_q;
   logic                         valid_q;
   logic                         ready_q;
   logic                         row_done_q;

   logic [COL_W-1:0]             col_eff;
   logic [ROW_W-1:0]             row_eff;
   logic [ROW_W-1:0]             lines_eff;
   logic                         accept;
   logic                         last_col;

   // Physical row holding the logical row 'age' rows older than 'row'.
   function automatic logic [ROW_W-1:0] row_back(input logic [ROW_W-1:0] row,
                                                 input int unsigned age);
      int unsigned idx;
      idx = 32'(row) + P_P_ROWS - age;
      if (idx >= P_P_ROWS) idx = idx - P_P_ROWS;
      return idx[ROW_W-1:0];
   endfunction

   always_comb begin
      accept    = I_ENABLE & I_PIXEL_VALID;
      col_eff   = I_FRAME_START ? '0 : wcol_q;
      row_eff   = I_FRAME_START ? '0 : wrow_q;
      lines_eff = I_FRAME_START ? '0 : lines_done_q;
      last_col  = (col_eff == COL_W'(P_P_COLUMNS - 1));

      column_d = '0;
      column_d[(P_P_ROWS-1)*W +: W] = I_PIXEL;
      for (int unsigned k = 1; k < P_P_ROWS; k++) begin
         // Rows older than the frame's completed-row count are stale; mask them.
         if (k <= 32'(lines_eff)) begin
            column_d[(P_P_ROWS-1-k)*W +: W] = row_mem[row_back(row_eff, k)][col_eff];
         end
      end

      wcol_d       = col_eff;
      wrow_d       = row_eff;
      lines_done_d = lines_eff;
      if (accept) begin
         if (last_col) begin
            wcol_d       = '0;
            wrow_d       = (row_eff == ROW_W'(P_P_ROWS - 1)) ? '0 : row_eff + 1'b1;
            lines_done_d = (lines_eff == ROW_W'(P_P_ROWS - 1)) ? lines_eff
                                                              : lines_eff + 1'b1;
         end else begin
            wcol_d = col_eff + 1'b1;
         end
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
         wcol_q       <= '0;
         wrow_q       <= '0;
         lines_done_q <= '0;
         column_q     <= '0;
         col_q        <= '0;
         valid_q      <= 1'b0;
         ready_q      <= 1'b0;
         row_done_q   <= 1'b0;
      end else if (I_ENABLE) begin
         valid_q    <= I_PIXEL_VALID;
         row_done_q <= I_PIXEL_VALID & last_col;
         if (I_PIXEL_VALID || I_FRAME_START) begin
            wcol_q       <= wcol_d;
            wrow_q       <= wrow_d;
            lines_done_q <= lines_done_d;
         end
         if (I_PIXEL_VALID) begin
            column_q <= column_d;
            col_q    <= col_eff;
            ready_q  <= (lines_eff == ROW_W'(P_P_ROWS - 1));
         end
      end else begin
         valid_q    <= 1'b0;
         row_done_q <= 1'b0;
      end
   end

   // Row store has no reset; stale contents are hidden by the age mask.
   always_ff @(posedge I_CLK) begin
      if (!I_RESET && accept) begin
         row_mem[row_eff][col_eff] <= I_PIXEL;
      end
   end

   assign O_COLUMN       = column_q;
   assign O_COLUMN_VALID = valid_q;
   assign O_COL          = col_q;
   assign O_WINDOW_READY = ready_q;
   assign O_ROW_DONE     = row_done_q;

endmodule

// File: doc/row_window_buffer.md
ROW_WINDOW_BUFFER -- requirements
Module: row_window_buffer

Interface
REQ-001 SHALL have parameter P_P_COLUMNS, default 640, pixels per row.
REQ-002 SHALL have parameter P_P_ROWS, default 3, window height in rows (min 2).
REQ-003 SHALL have parameter P_P_PIXEL_DEPTH, default 24, bits per pixel.
REQ-004 SHALL have port I_CLK  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port I_RESET  input  1  synchronous, active-high reset.
REQ-006 SHALL have port I_ENABLE  input  1  clock enable; low freezes all state and outputs.
REQ-007 SHALL have port I_PIXEL  input  P_P_PIXEL_DEPTH  incoming pixel, raster order.
REQ-008 SHALL have port I_PIXEL_VALID  input  1  I_PIXEL is accepted this cycle.
REQ-009 SHALL have port I_FRAME_START  input  1  restart the frame at (column 0, row 0).
REQ-010 SHALL have port O_COLUMN  output  P_P_ROWS*P_P_PIXEL_DEPTH  window column; slice 0 (LSBs) = oldest row, slice P_P_ROWS-1 = newest row.
REQ-011 SHALL have port O_COLUMN_VALID  output  1  one-cycle pulse per accepted pixel.
REQ-012 SHALL have port O_COL  output  $clog2(P_P_COLUMNS)  column index of O_COLUMN.
REQ-013 SHALL have port O_WINDOW_READY  output  1  every O_COLUMN slice holds current-frame data.
REQ-014 SHALL have port O_ROW_DONE  output  1  one-cycle pulse with the last column of a row.

Function
REQ-015 SHALL store P_P_ROWS rows of P_P_COLUMNS pixels in a circular row store with write column pointer wcol and physical row pointer wrow.
REQ-016 SHALL accept a pixel when I_ENABLE & I_PIXEL_VALID: write it at [wrow][wcol].
REQ-017 SHALL, 1 cycle after acceptance, present O_COLUMN = {accepted pixel, same column of the P_P_ROWS-1 previous logical rows}, O_COL = wcol at acceptance, O_COLUMN_VALID = 1.
REQ-018 SHALL advance wcol by 1 per accepted pixel; at wcol = P_P_COLUMNS-1 wrap wcol to 0, wrow to (wrow+1) mod P_P_ROWS, and assert O_ROW_DONE with that column's output.
REQ-019 SHALL keep a completed-row counter lines_done incremented at each row wrap and saturating at P_P_ROWS-1.
REQ-020 SHALL output zero in any older-row slice whose row age exceeds lines_done (rows not yet written this frame), regardless of stored contents.
REQ-021 SHALL set O_WINDOW_READY = (lines_done == P_P_ROWS-1), registered and aligned with O_COLUMN.
REQ-022 SHALL, on I_FRAME_START with I_ENABLE high, zero wcol, wrow and lines_done; a pixel accepted in the same cycle is stored and output as column 0 of row 0 of the new frame.
REQ-023 SHALL, on I_FRAME_START without I_PIXEL_VALID, reset pointers only: no write, no O_COLUMN_VALID.
REQ-024 SHALL, with I_ENABLE low, neither write nor move pointers, and hold O_COLUMN, O_COL, O_WINDOW_READY while forcing O_COLUMN_VALID and O_ROW_DONE low.
REQ-025 SHALL, with no accepted pixel, drive O_COLUMN_VALID and O_ROW_DONE low and hold O_COLUMN and O_COL.

Reset
REQ-026 SHALL, when I_RESET is high at a clock edge, clear wcol, wrow, lines_done, O_COLUMN, O_COL, O_COLUMN_VALID, O_WINDOW_READY and O_ROW_DONE to 0, overriding I_ENABLE, I_PIXEL_VALID and I_FRAME_START.
REQ-027 SHALL NOT clear row-store contents on reset; REQ-020 masking hides stale data.
REQ-028 SHALL, after reset mid-row, treat the next accepted pixel as column 0, row 0 of a new frame.

Verification (P_P_COLUMNS=4, P_P_ROWS=3, P_P_PIXEL_DEPTH=8)
REQ-029 SHALL verify reset: hold I_RESET 2 cycles with I_PIXEL_VALID=1 -> all outputs 0, no valid pulse.
REQ-030 SHALL verify first row: pixels 1,2,3,4 -> O_COLUMN = {1,0,0},{2,0,0},{3,0,0},{4,0,0} (newest,..,oldest), O_COL 0..3, O_ROW_DONE with column 3, O_WINDOW_READY 0.
REQ-031 SHALL verify fill: rows 11..14 then 21..24 -> column 0 of third row = {21,11,1}, O_WINDOW_READY 1 from that column on.
REQ-032 SHALL verify wrap: fourth row 31..34 -> column 2 = {33,23,13}, O_WINDOW_READY stays 1.
REQ-033 SHALL verify frame restart: pixel 99 with I_FRAME_START at column 2 -> O_COLUMN = {99,0,0}, O_COL 0, O_WINDOW_READY 0.
REQ-034 SHALL verify stall: I_ENABLE low 3 cycles with I_PIXEL_VALID high -> no valid pulses, outputs held, next enabled pixel lands in the following column.
